// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store unit: splits RV32I loads/stores into little-endian 8-bit dmem accesses.
// Latency: N+1 cycles (store), N+1+RD_LATENCY (load), 1 (rejected); the core is stalled meanwhile.
module lsu_byte_sequencer #(
  parameter int RD_LATENCY  = 1,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [7:0]  dmem_din,
  input  logic [7:0]  dmem_dout
);

  localparam bit LAT1 = (RD_LATENCY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] rdbuf_q, rdbuf_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  nbytes;
  logic [31:0] wshift;
  logic        cap_en;
  logic [1:0]  cap_idx;

  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    if (we) bad = f3[2] | (f3[1:0] == 2'b11);
    else    bad = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    if (CHECK_ALIGN) begin
      if ((f3[1:0] == 2'b01) && a[0])        bad = 1'b1;
      if ((f3[1:0] == 2'b10) && (a != 2'b00)) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] b, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {{24{~f3[2] & b[7]}}, b[7:0]};
      2'b01:   r = {{16{~f3[2] & b[15]}}, b[15:0]};
      default: r = b;
    endcase
    return r;
  endfunction

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign wshift = wdata_q >> {idx_q[1:0], 3'b000};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    rdbuf_d      = rdbuf_q;
    rdata_d      = rdata_q;
    cap_en       = 1'b0;
    cap_idx      = 2'b00;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    misalign_err = 1'b0;
    dmem_addr    = 32'd0;
    dmem_we      = 1'b0;
    dmem_din     = 8'd0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          we_d     = req_we;
          idx_d    = 3'd0;
          rdbuf_d  = 32'd0;
          state_d  = req_illegal(req_we, req_funct3, req_addr[1:0]) ? S_ERR : S_XFER;
        end
      end
      S_XFER: begin
        dmem_addr = addr_q + {29'd0, idx_q};
        if (we_q) begin
          // Gated by reset so a reset in mid-store commits no further byte.
          dmem_we  = ~sysreset;
          dmem_din = wshift[7:0];
        end else if (!LAT1) begin
          cap_en  = 1'b1;
          cap_idx = idx_q[1:0];
        end else if (idx_q != 3'd0) begin
          cap_en  = 1'b1;
          cap_idx = 2'(idx_q - 3'd1);
        end
        idx_d = 3'(idx_q + 3'd1);
        if (idx_q == 3'(nbytes - 3'd1))
          state_d = (!we_q && LAT1) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        cap_en  = 1'b1;
        cap_idx = 2'(idx_q - 3'd1);
        state_d = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        resp_valid   = 1'b1;
        misalign_err = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int b = 0; b < 4; b++) begin
      if (cap_en && (cap_idx == 2'(b)))
        rdbuf_d[8*b +: 8] = dmem_dout;
    end

    // Extend on the way into DONE so resp_rdata is already valid alongside resp_valid.
    if ((state_d == S_DONE) && !we_q)
      rdata_d = load_extend(rdbuf_d, funct3_q);
  end

  assign stall      = req_valid & ~resp_valid;
  assign resp_rdata = rdata_q;

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      rdbuf_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdbuf_q  <= rdbuf_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Randomized bench for lsu_byte_sequencer against a transaction-level memory/response model.
module tb_lsu_byte_sequencer;
  localparam int RD_LAT = 1;
  localparam int MEM_SZ = 1024;

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_din;
  logic [7:0]  dmem_dout;

  always #5 sysclk = ~sysclk;

  lsu_byte_sequencer #(.RD_LATENCY(RD_LAT), .CHECK_ALIGN(1'b1)) dut (
    .sysclk(sysclk), .sysreset(sysreset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign_err(misalign_err), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_din(dmem_din), .dmem_dout(dmem_dout)
  );

  // Data memory, aliased onto the low address bits.
  logic [7:0] mem [MEM_SZ];
  logic [7:0] mem_rd_q;
  logic       init_we;
  logic [9:0] init_addr;
  logic [7:0] init_dat;

  always @(posedge sysclk) begin
    if (init_we)      mem[init_addr] <= init_dat;
    else if (dmem_we) mem[dmem_addr[9:0]] <= dmem_din;
    mem_rd_q <= mem[dmem_addr[9:0]];
  end
  assign dmem_dout = (RD_LAT == 0) ? mem[dmem_addr[9:0]] : mem_rd_q;

  logic [7:0]  ref_mem [MEM_SZ];
  logic [31:0] ref_rdata;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_mem_image(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < MEM_SZ; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  // Called in the middle of an IDLE cycle; returns in the middle of the next IDLE cycle.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit perturb);
    int          n, lat, cyc;
    bit          bad, done, inx;
    longint      v;
    logic [31:0] exp_data, sh;
    logic [9:0]  a;

    n = 1 << f3[1:0];
    if (we) bad = (f3 > 3'd2);
    else    bad = (f3 == 3'd3) || (f3 >= 3'd6);
    if (!bad && (addr % n) != 0) bad = 1'b1;
    lat = bad ? 1 : (we ? n + 1 : n + 1 + RD_LAT);

    exp_data = ref_rdata;
    if (!bad && !we) begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        a = addr[9:0] + 10'(i);
        v += longint'(ref_mem[a]) << (8 * i);
      end
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v -= (longint'(1) << (8 * n));
      exp_data = v[31:0];
    end

    check("ready", req_ready, 1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    #1;
    check("stall_acc", stall, 1);

    cyc = 0; done = 1'b0;
    while (!done && cyc < lat + 3) begin
      @(negedge sysclk);
      cyc++;
      inx = !bad && (cyc <= n);
      check("dmem_we", dmem_we, inx && we);
      check("dmem_addr", dmem_addr, inx ? addr + 32'(cyc - 1) : 32'd0);
      if (inx && we) begin
        sh = wdata >> (8 * (cyc - 1));
        check("dmem_din", dmem_din, {24'd0, sh[7:0]});
      end else if (!inx) begin
        check("dmem_din_idle", dmem_din, 0);
      end
      check("resp_valid", resp_valid, cyc == lat);
      check("stall", stall, cyc != lat);
      if (resp_valid) begin
        done = 1'b1;
        check("misalign_err", misalign_err, bad);
        check("resp_rdata", resp_rdata, exp_data);
      end else if (perturb) begin
        req_addr = $urandom(); req_wdata = $urandom();
        req_funct3 = 3'($urandom_range(0, 7)); req_we = 1'($urandom_range(0, 1));
      end
    end
    check("timeout", done, 1);
    req_valid = 1'b0;

    if (!bad && we) begin
      for (int i = 0; i < n; i++) begin
        sh = wdata >> (8 * i);
        a = addr[9:0] + 10'(i);
        ref_mem[a] = sh[7:0];
      end
    end
    if (!bad && !we) ref_rdata = exp_data;
    @(negedge sysclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    n_checks = 0; n_errors = 0; ref_rdata = 32'd0;
    sysreset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    init_we = 1'b1; init_addr = 10'd0; init_dat = 8'd0;

    for (int i = 0; i < MEM_SZ; i++) begin
      init_addr = 10'(i);
      init_dat  = 8'($urandom());
      ref_mem[i] = init_dat;
      @(negedge sysclk);
    end
    init_we = 1'b0;
    @(negedge sysclk);
    sysreset = 1'b0;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_din", dmem_din, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_stall", stall, 0);
    check_mem_image("init_mem");

    run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    check_mem_image("sw_mem");
    run_op(1'b1, 3'b000, 32'h0000_0203, 32'h0000_0080, 1'b0);
    run_op(1'b0, 3'b000, 32'h0000_0203, 32'h0, 1'b0);
    check("lb_val", resp_rdata, 32'hFFFF_FF80);
    run_op(1'b0, 3'b100, 32'h0000_0203, 32'h0, 1'b0);
    check("lbu_val", resp_rdata, 32'h0000_0080);
    run_op(1'b1, 3'b010, 32'h0000_0300, 32'h4433_2211, 1'b0);
    run_op(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b0);
    check("lw_val", resp_rdata, 32'h4433_2211);
    run_op(1'b0, 3'b001, 32'h0000_0201, 32'h0, 1'b0);
    run_op(1'b1, 3'b011, 32'h0000_0200, 32'h1234_5678, 1'b0);
    run_op(1'b1, 3'b001, 32'h0000_0200, 32'h0000_8001, 1'b0);
    run_op(1'b0, 3'b101, 32'h0000_0200, 32'h0, 1'b0);
    check("lhu_val", resp_rdata, 32'h0000_8001);
    run_op(1'b0, 3'b001, 32'h0000_0200, 32'h0, 1'b0);
    check("lh_val", resp_rdata, 32'hFFFF_8001);
    check_mem_image("directed_mem");

    // Reset in the second write cycle of a word store.
    run_op(1'b1, 3'b010, 32'h0000_0100, 32'h0, 1'b0);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    @(negedge sysclk);
    check("rst6_we1", dmem_we, 1);
    check("rst6_din1", dmem_din, 32'hEF);
    @(negedge sysclk);
    sysreset = 1'b1;
    #1;
    check("rst6_we2", dmem_we, 0);
    @(negedge sysclk);
    sysreset = 1'b0; req_valid = 1'b0;
    #1;
    check("rst6_resp_valid", resp_valid, 0);
    check("rst6_misalign", misalign_err, 0);
    check("rst6_dmem_we", dmem_we, 0);
    check("rst6_dmem_addr", dmem_addr, 0);
    check("rst6_dmem_din", dmem_din, 0);
    check("rst6_rdata", resp_rdata, 0);
    check("rst6_stall", stall, 0);
    check("rst6_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("rst6_no_resp", resp_valid, 0);
    end
    ref_mem[10'h100] = 8'hEF;
    ref_rdata = 32'd0;
    check_mem_image("rst6_mem");
    run_op(1'b0, 3'b100, 32'h0000_0100, 32'h0, 1'b0);
    check("rst6_readback", resp_rdata, 32'h0000_00EF);
    run_op(1'b0, 3'b100, 32'h0000_0101, 32'h0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      ra = $urandom();
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rf = 3'($urandom_range(0, 7));
      run_op(1'($urandom_range(0, 1)), rf, ra, $urandom(), 1'($urandom_range(0, 1)));
    end
    check_mem_image("final_mem");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
